async_fifo_rd_stream: RTL
=========================

Name: async_fifo_rd_stream

Overview:
- Read-side consumer for the Async_FIFO read port, in the rd_clk domain.
- Pops words whenever the FIFO is non-empty and there is downstream space, absorbing the FIFO read latency with a small credit-managed buffer.
- Presents the data as a valid/ready stream to downstream logic at full throughput (one word per rd_clk) with no dropped or duplicated words.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and the stream data.
- BUF_DEPTH, 4, entries in the output buffer; must be >= 2 and a power of 2.
- CNT_WIDTH, clogb2(BUF_DEPTH), width of the credit and occupancy counters.

Ports:
- rd_clk  input  1  read-domain clock, same clock as the FIFO read port.
- rst  input  1  synchronous, active-high reset.
- drain_en  input  1  allows new pops when high; in-flight words still land when low.
- empty  input  1  FIFO empty flag.
- almost_empty  input  1  FIFO almost-empty flag; informational only.
- fifo_valid  input  1  FIFO dout-valid strobe, one pulse per completed pop.
- fifo_dout  input  DATA_WIDTH  FIFO read data, sampled when fifo_valid=1.
- rd_en  output  1  FIFO pop request.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accepts.
- m_data  output  DATA_WIDTH  stream data, the buffer head.
- proto_err  output  1  sticky: fifo_valid arrived with no pop outstanding.

Behaviour:
- Reset (rst=1 at a rising edge of rd_clk):
  - inflight, buf_cnt, wptr and rptr all clear to 0; proto_err clears to 0.
  - rd_en=0, m_valid=0, m_data=0.
  - Reset mid-operation discards buffered and in-flight words. A fifo_valid that arrives after reset is treated as a protocol error.
- pop = m_valid && m_ready.
- rd_en is combinational:
  - rd_en = !rst && drain_en && !empty && (inflight + buf_cnt - pop < BUF_DEPTH).
  - Arithmetic is done at CNT_WIDTH+1 bits; the sum never exceeds BUF_DEPTH.
- inflight:
  - +1 on rd_en, -1 on fifo_valid; both in the same cycle leaves it unchanged.
  - It never decrements below 0. fifo_valid with inflight=0 sets proto_err and the word is dropped.
- Buffer write: on fifo_valid with inflight>0, fifo_dout is written to buf[wptr], wptr increments and buf_cnt increments.
- Buffer read: on pop, rptr increments and buf_cnt decrements.
- Simultaneous push and pop: buf_cnt is unchanged and both pointers advance.
- Pointers wrap modulo BUF_DEPTH.
- Outputs:
  - m_valid = (buf_cnt != 0).
  - m_data = buf[rptr], registered storage with no combinational path from fifo_dout.
  - m_data is held stable while m_valid && !m_ready.
- Latency: empty falling with space available -> rd_en in the same cycle -> fifo_valid after the FIFO latency (1 cycle) -> m_valid on the following cycle.
- Throughput: with m_ready held high, one word per cycle in steady state.
- drain_en low: rd_en is forced to 0. Outstanding words still complete, and the buffer continues draining to downstream.
- Overflow is impossible by construction because credits reserve space before each pop.

Optional Feature:
- Macro: ASYNC_FIFO_RD_STAT_EN
- Defined:
  - Adds output beat_cnt[15:0], incremented on every pop, wrapping at 16'hFFFF -> 0, cleared by rst.
  - Adds output underrun[15:0], incremented on cycles where drain_en && m_ready && !m_valid && empty; saturates at 16'hFFFF; cleared by rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package async_fifo_pkg holds:
  - the clogb2 function;
  - the default DATA_WIDTH and BUF_DEPTH localparams;
  - the buffer state struct (wptr, rptr, buf_cnt).
- One sub-module, async_fifo_rd_buf: the BUF_DEPTH-entry circular buffer with push, pop, count, head data and reset.
- Credit and rd_en logic, proto_err and the optional stats stay in the top module.

Test Plan:
- Basic drain: FIFO pre-loaded with 17, 20, 32, 33; m_ready=1 -> rd_en for 4 cycles, m_data sequence 17, 20, 32, 33, then m_valid=0 and rd_en=0 with empty=1.
- Backpressure: 8 words 1..8 queued, m_ready=0 -> exactly BUF_DEPTH=4 pops issued, then rd_en=0 and m_data=1 held. Release m_ready -> words 1..8 in order, no gaps after refill.
- Full rate: continuous FIFO data, m_ready=1 -> one rd_en and one m_valid beat per cycle, inflight+buf_cnt never exceeds 4.
- drain_en toggle: drop drain_en one cycle after rd_en -> the in-flight word still appears on m_data, no further pops, buf_cnt stable.
- Protocol error and reset: inject fifo_valid with inflight=0 -> proto_err=1 and the word is not buffered. Assert rst mid-stream with 3 words buffered -> m_valid=0, proto_err=0, counters 0 on the next cycle.
- ASYNC_FIFO_RD_STAT_EN: drain 10 words -> beat_cnt=10. Hold m_ready=1 with empty=1 for 5 cycles -> underrun=5.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared sizing helper, default widths and buffer state type for the async FIFO read-side stream.
// Pointer fields are sized for up to 256 buffer entries.
package async_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUF_DEPTH_DEF  = 4;
    localparam int PTR_W_MAX      = 8;

    function automatic int clogb2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1)
            width = width + 1;
        return width;
    endfunction

    typedef struct packed {
        logic [PTR_W_MAX-1:0] wptr;
        logic [PTR_W_MAX-1:0] rptr;
        logic [PTR_W_MAX:0]   buf_cnt;
    } buf_state_t;
endpackage

// File: rtl/async_fifo_rd_buf.sv
// Circular output buffer of BUF_DEPTH registered entries with push/pop pointers and occupancy.
// Latency: a word pushed into an empty buffer is at the head on the next cycle.
// Backpressure: none internally; the caller's credits guarantee no push when full.
module async_fifo_rd_buf
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int CNT_WIDTH  = clogb2(BUF_DEPTH)
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic [CNT_WIDTH:0]    cnt
);
    localparam logic [PTR_W_MAX-1:0] PTR_MASK = PTR_W_MAX'(BUF_DEPTH - 1);
    localparam logic [PTR_W_MAX-1:0] PTR_ONE  = PTR_W_MAX'(1);
    localparam logic [PTR_W_MAX:0]   CNT_ONE  = {{PTR_W_MAX{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    buf_state_t            st;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            st <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[st.wptr[CNT_WIDTH-1:0]] <= push_dat;
                st.wptr <= (st.wptr + PTR_ONE) & PTR_MASK;
            end
            if (pop)
                st.rptr <= (st.rptr + PTR_ONE) & PTR_MASK;
            // Simultaneous push and pop leaves the count alone.
            case ({push, pop})
                2'b10:   st.buf_cnt <= st.buf_cnt + CNT_ONE;
                2'b01:   st.buf_cnt <= st.buf_cnt - CNT_ONE;
                default: st.buf_cnt <= st.buf_cnt;
            endcase
        end
    end

    assign head_dat = mem[st.rptr[CNT_WIDTH-1:0]];
    assign cnt      = st.buf_cnt[CNT_WIDTH:0];
endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side stream adapter for the async FIFO: pops on credit, buffers words, presents valid/ready.
// Latency: rd_en in the cycle empty drops, fifo_valid one cycle later, m_valid the cycle after.
// Backpressure: pops stop once in-flight plus buffered words would exceed BUF_DEPTH.
// Build option ASYNC_FIFO_RD_STAT_EN adds beat_cnt and underrun counters.
module async_fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int CNT_WIDTH  = clogb2(BUF_DEPTH)
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  drain_en,
    input  logic                  empty,
    input  logic                  almost_empty,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  proto_err
`ifdef ASYNC_FIFO_RD_STAT_EN
   ,output logic [15:0]           beat_cnt,
    output logic [15:0]           underrun
`endif
);
    localparam int                 CW1       = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH:0] DEPTH_CNT = CW1'(BUF_DEPTH);
    localparam logic [CNT_WIDTH:0] CNT_ONE   = CW1'(1);

    logic [CNT_WIDTH:0] inflight;
    logic [CNT_WIDTH:0] buf_cnt;
    logic [CNT_WIDTH:0] credit_used;
    logic               pop;
    logic               land;
    logic               stray;
    logic               unused_almost_empty;

    assign unused_almost_empty = almost_empty;

    assign pop   = m_valid && m_ready;
    assign land  = fifo_valid && (inflight != '0);
    assign stray = fifo_valid && (inflight == '0);

    // A word leaving this cycle frees its slot for a pop in the same cycle.
    assign credit_used = inflight + buf_cnt - {{CNT_WIDTH{1'b0}}, pop};
    assign rd_en       = !rst && drain_en && !empty && (credit_used < DEPTH_CNT);
    assign m_valid     = (buf_cnt != '0);

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            inflight  <= '0;
            proto_err <= 1'b0;
        end else begin
            case ({rd_en, land})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
            if (stray)
                proto_err <= 1'b1;
        end
    end

    async_fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_buf (
        .rd_clk   (rd_clk),
        .rst      (rst),
        .push     (land),
        .push_dat (fifo_dout),
        .pop      (pop),
        .head_dat (m_data),
        .cnt      (buf_cnt)
    );

`ifdef ASYNC_FIFO_RD_STAT_EN
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            beat_cnt <= '0;
            underrun <= '0;
        end else begin
            if (pop)
                beat_cnt <= beat_cnt + 16'd1;
            if (drain_en && m_ready && !m_valid && empty && (underrun != 16'hFFFF))
                underrun <= underrun + 16'd1;
        end
    end
`endif
endmodule
